// File: rtl/jk_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : jk_reg_arbiter
//  Purpose  : Shares one WIDTH-bit JK register bank between N_REQ requesters.
//             A round-robin arbiter accepts at most one J/K command per cycle
//             through a valid/ready handshake. A requester may lock the bank
//             across several operations. The lock is released after LOCK_MAX
//             idle cycles; LOCK_MAX = 0 means the lock never times out.
//  Ports    : clk          rising-edge clock
//             rst_i        synchronous active-high reset
//             req_valid_i  per-requester command valid            [N_REQ]
//             req_j_i      J vectors, requester r at [r*WIDTH +: WIDTH]
//             req_k_i      K vectors, same packing
//             req_lock_i   keep ownership after this op           [N_REQ]
//             req_ready_o  one-hot-or-zero accept (combinational)
//             q_o          register bank contents
//             grant_id_o   id of the last accepted requester
//             upd_o        one-cycle pulse, the cycle after an accept
//             busy_o       high while the bank is locked
//  Revision : 1.0  initial release
// ============================================================================
module jk_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    input  logic [N_REQ*WIDTH-1:0]     req_j_i,
    input  logic [N_REQ*WIDTH-1:0]     req_k_i,
    input  logic [N_REQ-1:0]           req_lock_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [WIDTH-1:0]           q_o,
    output logic [$clog2(N_REQ)-1:0]   grant_id_o,
    output logic                       upd_o,
    output logic                       busy_o
);

    localparam int PTR_W = $clog2(N_REQ);
    // A zero-width counter is not legal, so keep one bit when the timeout is off.
    localparam int CNT_W = (LOCK_MAX > 0) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = (LOCK_MAX > 0) ? CNT_W'(LOCK_MAX - 1) : '0;
    localparam logic [CNT_W-1:0] C_CNT_SAT  = '1;

    localparam logic [0:0] S_ARB    = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    // State and datapath registers
    logic [0:0]       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [PTR_W-1:0] r_gid;
    logic             r_upd;

    // Next-state values
    logic [0:0]       w_state_nxt;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_owner_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Arbitration and accept decode
    logic             w_win_found;
    logic [PTR_W-1:0] w_win_id;
    logic [N_REQ-1:0] w_ready;
    logic             w_acc;
    logic [PTR_W-1:0] w_acc_id;
    logic [WIDTH-1:0] w_sel_j;
    logic [WIDTH-1:0] w_sel_k;
    logic             w_sel_lock;

    // Requester index following v, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] v);
        if (int'(v) >= N_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    // Round-robin scan starting at r_ptr; the first valid requester wins.
    always_comb begin : p_winner
        int w_idx;
        w_win_found = 1'b0;
        w_win_id    = '0;
        w_idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_win_found && req_valid_i[w_idx]) begin
                w_win_found = 1'b1;
                w_win_id    = PTR_W'(w_idx);
            end
        end
    end

    // Output process: ready decode. Forced low during reset so nothing
    // can handshake in a cycle whose accept would be discarded.
    always_comb begin : p_ready
        w_ready = '0;
        if (!rst_i) begin
            if (r_state == S_ARB) begin
                if (w_win_found) begin
                    w_ready[w_win_id] = 1'b1;
                end
            end else begin
                w_ready[r_owner] = req_valid_i[r_owner];
            end
        end
    end

    assign w_acc      = |(req_valid_i & w_ready);
    assign w_acc_id   = (r_state == S_ARB) ? w_win_id : r_owner;
    assign w_sel_j    = req_j_i[int'(w_acc_id) * WIDTH +: WIDTH];
    assign w_sel_k    = req_k_i[int'(w_acc_id) * WIDTH +: WIDTH];
    assign w_sel_lock = req_lock_i[w_acc_id];

    // Next-state process
    always_comb begin : p_next
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_ARB: begin
                if (w_acc) begin
                    w_ptr_nxt = f_inc(w_acc_id);
                    if (w_sel_lock) begin
                        w_state_nxt = S_LOCKED;
                        w_owner_nxt = w_acc_id;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_LOCKED: begin
                // An owner accept always wins over a timeout in the same cycle.
                if (w_acc) begin
                    if (w_sel_lock) begin
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_ARB;
                        w_ptr_nxt   = f_inc(r_owner);
                    end
                end else if ((LOCK_MAX > 0) && (r_cnt == C_CNT_LAST)) begin
                    w_state_nxt = S_ARB;
                    w_ptr_nxt   = f_inc(r_owner);
                    w_cnt_nxt   = '0;
                end else if (r_cnt != C_CNT_SAT) begin
                    // Saturate rather than wrap when the timeout is disabled.
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // State register process, including the JK bank update.
    always_ff @(posedge clk) begin : p_regs
        if (rst_i) begin
            r_state <= S_ARB;
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_gid   <= '0;
            r_upd   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_upd   <= w_acc;
            if (w_acc) begin
                // Per-bit JK: set, clear, toggle or hold.
                r_q   <= (w_sel_j & ~r_q) | (~w_sel_k & r_q);
                r_gid <= w_acc_id;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign q_o         = r_q;
    assign grant_id_o  = r_gid;
    assign upd_o       = r_upd;
    assign busy_o      = (r_state == S_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_jk_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_reg_arbiter
//  Purpose  : Self-checking bench for jk_reg_arbiter (N_REQ=4, WIDTH=8,
//             LOCK_MAX=4): directed vector table, hand-written timeout and
//             reset-in-lock sequences, then random stimulus against a
//             behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int LM = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_valid_i;
    logic [N*W-1:0] req_j_i;
    logic [N*W-1:0] req_k_i;
    logic [N-1:0]   req_lock_i;
    logic [N-1:0]   req_ready_o;
    logic [W-1:0]   q_o;
    logic [1:0]     grant_id_o;
    logic           upd_o;
    logic           busy_o;

    always #5 clk = ~clk;

    jk_reg_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .LOCK_MAX (LM)
    ) u_dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_j_i     (req_j_i),
        .req_k_i     (req_k_i),
        .req_lock_i  (req_lock_i),
        .req_ready_o (req_ready_o),
        .q_o         (q_o),
        .grant_id_o  (grant_id_o),
        .upd_o       (upd_o),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_q, m_ptr, m_owner, m_idle, m_gid;
    bit m_locked, m_upd;

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (rst_i) return r;
        if (m_locked) begin
            r[m_owner] = req_valid_i[m_owner];
            return r;
        end
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (m_ptr + i) % N;
            if (req_valid_i[idx]) begin
                r[idx] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_update(input logic [N-1:0] rdy);
        int id;
        id = -1;
        if (rst_i) begin
            m_q = 0; m_ptr = 0; m_locked = 0; m_owner = 0;
            m_idle = 0; m_gid = 0; m_upd = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (rdy[i] && req_valid_i[i]) id = i;
        end
        m_upd = (id >= 0);
        if (id >= 0) begin
            for (int b = 0; b < W; b++) begin
                case ({req_j_i[id*W+b], req_k_i[id*W+b]})
                    2'b10:   m_q[b] = 1'b1;
                    2'b01:   m_q[b] = 1'b0;
                    2'b11:   m_q[b] = ~m_q[b];
                    default: m_q[b] = m_q[b];
                endcase
            end
            m_gid = id;
        end
        if (!m_locked) begin
            if (id >= 0) begin
                m_ptr = (id + 1) % N;
                if (req_lock_i[id]) begin
                    m_locked = 1; m_owner = id; m_idle = 0;
                end
            end
        end else if (id >= 0) begin
            if (req_lock_i[id]) m_idle = 0;
            else begin
                m_locked = 0; m_ptr = (m_owner + 1) % N;
            end
        end else begin
            m_idle++;
            if (LM > 0 && m_idle >= LM) begin
                m_locked = 0; m_ptr = (m_owner + 1) % N;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    logic [N-1:0] ready_seen;

    task automatic drive(input logic r, input logic [N-1:0] v, input logic [W-1:0] j,
                         input logic [W-1:0] k, input logic [N-1:0] l);
        rst_i       = r;
        req_valid_i = v;
        req_j_i     = {N{j}};
        req_k_i     = {N{k}};
        req_lock_i  = l;
    endtask

    // One clock: ready checked mid-cycle, registered outputs just after the edge.
    task automatic tick();
        logic [N-1:0] er;
        @(negedge clk);
        er = model_ready();
        ready_seen = req_ready_o;
        chk("model_ready", ready_seen, er);
        model_update(er);
        @(posedge clk);
        #1;
        chk("model_q", q_o, m_q);
        chk("model_gid", grant_id_o, m_gid);
        chk("model_upd", upd_o, m_upd);
        chk("model_busy", busy_o, m_locked);
    endtask

    typedef struct packed {
        logic         rst;
        logic [3:0]   valid;
        logic [7:0]   j;
        logic [7:0]   k;
        logic [3:0]   lock;
        logic [3:0]   e_ready;
        logic [7:0]   e_q;
        logic [1:0]   e_gid;
        logic         e_upd;
        logic         e_busy;
    } vec_t;

    vec_t tv [20];

    initial begin
        // reset, then JK semantics on req0
        tv[0]  = '{1'b1, 4'hF, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 4'hF, 8'h00, 8'h00, 4'h0, 4'h0, 8'h00, 2'd0, 1'b0, 1'b0};
        tv[2]  = '{1'b0, 4'hF, 8'h0F, 8'h00, 4'h0, 4'h1, 8'h0F, 2'd0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 4'h1, 8'hFF, 8'hFF, 4'h0, 4'h1, 8'hF0, 2'd0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 4'h1, 8'h00, 8'h30, 4'h0, 4'h1, 8'hC0, 2'd0, 1'b1, 1'b0};
        tv[5]  = '{1'b0, 4'h1, 8'h00, 8'h00, 4'h0, 4'h1, 8'hC0, 2'd0, 1'b1, 1'b0};
        // req3 alone brings the pointer back to 0, then full round robin
        tv[6]  = '{1'b0, 4'h8, 8'h00, 8'h00, 4'h0, 4'h8, 8'hC0, 2'd3, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h1, 8'hC0, 2'd0, 1'b1, 1'b0};
        tv[8]  = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h2, 8'hC0, 2'd1, 1'b1, 1'b0};
        tv[9]  = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h4, 8'hC0, 2'd2, 1'b1, 1'b0};
        tv[10] = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h8, 8'hC0, 2'd3, 1'b1, 1'b0};
        tv[11] = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h1, 8'hC0, 2'd0, 1'b1, 1'b0};
        tv[12] = '{1'b0, 4'hF, 8'h00, 8'h00, 4'h0, 4'h2, 8'hC0, 2'd1, 1'b1, 1'b0};
        // pointer to 1, then req1 locks while req0/req2 wait
        tv[13] = '{1'b0, 4'h1, 8'h00, 8'h00, 4'h0, 4'h1, 8'hC0, 2'd0, 1'b1, 1'b0};
        tv[14] = '{1'b0, 4'h7, 8'h00, 8'h00, 4'h2, 4'h2, 8'hC0, 2'd1, 1'b1, 1'b1};
        tv[15] = '{1'b0, 4'h7, 8'h01, 8'h00, 4'h2, 4'h2, 8'hC1, 2'd1, 1'b1, 1'b1};
        tv[16] = '{1'b0, 4'h7, 8'h01, 8'h01, 4'h2, 4'h2, 8'hC0, 2'd1, 1'b1, 1'b1};
        tv[17] = '{1'b0, 4'h5, 8'h00, 8'h00, 4'h0, 4'h0, 8'hC0, 2'd1, 1'b0, 1'b1};
        tv[18] = '{1'b0, 4'h7, 8'h02, 8'h00, 4'h0, 4'h2, 8'hC2, 2'd1, 1'b1, 1'b0};
        tv[19] = '{1'b0, 4'h5, 8'h00, 8'h00, 4'h0, 4'h4, 8'hC2, 2'd2, 1'b1, 1'b0};

        drive(1'b1, 4'hF, 8'h00, 8'h00, 4'h0);

        for (int i = 0; i < 20; i++) begin
            drive(tv[i].rst, tv[i].valid, tv[i].j, tv[i].k, tv[i].lock);
            tick();
            chk($sformatf("vec%0d_ready", i), ready_seen, tv[i].e_ready);
            chk($sformatf("vec%0d_q", i), q_o, tv[i].e_q);
            chk($sformatf("vec%0d_gid", i), grant_id_o, tv[i].e_gid);
            chk($sformatf("vec%0d_upd", i), upd_o, tv[i].e_upd);
            chk($sformatf("vec%0d_busy", i), busy_o, tv[i].e_busy);
        end

        // Timeout: req3 locks, then goes idle while req0 waits.
        drive(1'b0, 4'h8, 8'h00, 8'h00, 4'h8);
        tick();
        chk("to_lock_busy", busy_o, 1);
        chk("to_lock_gid", grant_id_o, 3);
        drive(1'b0, 4'h1, 8'h00, 8'h00, 4'h0);
        for (int i = 0; i < LM; i++) begin
            tick();
            chk($sformatf("to_idle%0d_ready", i), ready_seen, 0);
            chk($sformatf("to_idle%0d_upd", i), upd_o, 0);
            if (i < LM - 1) chk($sformatf("to_idle%0d_busy", i), busy_o, 1);
        end
        chk("to_busy_fall", busy_o, 0);
        tick();
        chk("to_req0_ready", ready_seen, 4'h1);
        chk("to_req0_gid", grant_id_o, 0);
        chk("to_req0_upd", upd_o, 1);

        // Reset while req2 holds the lock with q=0xAA.
        drive(1'b0, 4'h4, 8'hAA, 8'h55, 4'h4);
        tick();
        chk("rl_q", q_o, 8'hAA);
        chk("rl_busy", busy_o, 1);
        chk("rl_gid", grant_id_o, 2);
        drive(1'b1, 4'hF, 8'hFF, 8'h00, 4'hF);
        tick();
        chk("rl_rst_ready", ready_seen, 0);
        chk("rl_rst_q", q_o, 0);
        chk("rl_rst_busy", busy_o, 0);
        chk("rl_rst_upd", upd_o, 0);
        drive(1'b0, 4'hF, 8'h00, 8'h00, 4'h0);
        tick();
        chk("rl_after_ready", ready_seen, 4'h1);
        chk("rl_after_gid", grant_id_o, 0);

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            rst_i       = ($urandom_range(0, 59) == 0);
            req_valid_i = ($urandom_range(0, 2) == 0) ? N'($urandom)
                                                       : N'($urandom & $urandom & $urandom);
            req_j_i     = $urandom;
            req_k_i     = $urandom;
            req_lock_i  = N'($urandom & $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
